// File: rtl/async_receiver.sv
// ============================================================================
// async_receiver : 8N1 serial receiver with 8x oversampling, glitch filter,
// frame-error and line-idle / end-of-packet detection.   Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module async_receiver #(
    parameter int ClkFrequency          = 27000000,
    parameter int Baud                  = 115200,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int W = BaudGeneratorAccWidth;
    localparam longint INC_WIDE =
        ((longint'(Baud) * 8 << (W - 7)) + longint'(ClkFrequency >> 8)) / longint'(ClkFrequency >> 7);
    localparam logic [W:0] BAUD_INC   = INC_WIDE[W:0];
    localparam logic [6:0] IDLE_TICKS = 7'd80;

    typedef enum logic [3:0] {
        S_IDLE, S_START,
        S_BIT0, S_BIT1, S_BIT2, S_BIT3, S_BIT4, S_BIT5, S_BIT6, S_BIT7,
        S_STOP, S_BREAK
    } state_t;

    logic [W:0] acc_q, acc_d;
    logic [1:0] sync_q;
    logic [1:0] filt_q, filt_d;
    logic       rxd_bit_q, rxd_bit_d;
    state_t     state_q, state_d;
    logic [2:0] spacing_q, spacing_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       ferr_q, ferr_d;
    logic [6:0] idle_cnt_q, idle_cnt_d;
    logic       eop_q, eop_d;
    logic       tick8;

    assign tick8 = acc_q[W];
    assign acc_d = {1'b0, acc_q[W-1:0]} + BAUD_INC;

    // Majority-style filter: output only flips once the counter saturates.
    always_comb begin
        filt_d    = filt_q;
        rxd_bit_d = rxd_bit_q;
        if (tick8) begin
            if (sync_q[1] && filt_q != 2'd3)
                filt_d = filt_q + 2'd1;
            else if (!sync_q[1] && filt_q != 2'd0)
                filt_d = filt_q - 2'd1;
            if (filt_q == 2'd3)
                rxd_bit_d = 1'b1;
            else if (filt_q == 2'd0)
                rxd_bit_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        spacing_d = spacing_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        if (tick8) begin
            spacing_d = spacing_q + 3'd1;
            case (state_q)
                S_IDLE: begin
                    if (!rxd_bit_q) begin
                        state_d   = S_START;
                        spacing_d = 3'd0;
                    end
                end
                // Half-bit check so a short low pulse is rejected as a glitch.
                S_START: begin
                    if (spacing_q == 3'd3) begin
                        spacing_d = 3'd0;
                        state_d   = rxd_bit_q ? S_IDLE : S_BIT0;
                    end
                end
                S_BIT0, S_BIT1, S_BIT2, S_BIT3, S_BIT4, S_BIT5, S_BIT6, S_BIT7: begin
                    if (spacing_q == 3'd7) begin
                        shift_d = {rxd_bit_q, shift_q[7:1]};
                        state_d = state_t'(state_q + 4'd1);
                    end
                end
                S_STOP: begin
                    if (spacing_q == 3'd7) begin
                        if (rxd_bit_q) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxd_bit_q)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != S_IDLE || !rxd_bit_q)
            idle_cnt_d = 7'd0;
        else if (tick8 && idle_cnt_q != IDLE_TICKS)
            idle_cnt_d = idle_cnt_q + 7'd1;
        eop_d = (idle_cnt_d == IDLE_TICKS) && (idle_cnt_q != IDLE_TICKS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            sync_q     <= 2'b11;
            filt_q     <= 2'd3;
            rxd_bit_q  <= 1'b1;
            state_q    <= S_IDLE;
            spacing_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            idle_cnt_q <= 7'd0;
            eop_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            sync_q     <= {sync_q[0], RxD};
            filt_q     <= filt_d;
            rxd_bit_q  <= rxd_bit_d;
            state_q    <= state_d;
            spacing_q  <= spacing_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            idle_cnt_q <= idle_cnt_d;
            eop_q      <= eop_d;
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_ready  = ready_q;
    assign RxD_frame_error = ferr_q;
    assign RxD_idle        = (idle_cnt_q == IDLE_TICKS);
    assign RxD_endofpacket = eop_q;

endmodule

`default_nettype wire

// File: tb/tb_async_receiver.sv
// ============================================================================
// tb_async_receiver : directed bench for async_receiver at 27 MHz / 115200.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_async_receiver;

    // 27e6 / 115200 = 234.375 clocks per bit
    localparam int BIT_CLKS = 234;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    int total = 0;
    int bad   = 0;

    int         ready_cnt   = 0;
    int         err_cnt     = 0;
    int         eop_cnt     = 0;
    int         both_cnt    = 0;
    int         eop_bad_cnt = 0;
    logic       prev_idle   = 1'b0;
    logic [7:0] log_q[$];

    async_receiver dut (
        .clk             (clk),
        .rst             (rst),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_frame_error (RxD_frame_error),
        .RxD_idle        (RxD_idle),
        .RxD_endofpacket (RxD_endofpacket)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            ready_cnt++;
            log_q.push_back(RxD_data);
        end
        if (RxD_frame_error) err_cnt++;
        if (RxD_data_ready && RxD_frame_error) both_cnt++;
        if (RxD_endofpacket) begin
            eop_cnt++;
            if (!(RxD_idle && !prev_idle)) eop_bad_cnt++;
        end
        prev_idle = RxD_idle;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bit_time(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        RxD = 1'b0;
        bit_time(1);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            bit_time(1);
        end
        RxD = stop_val;
        bit_time(1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (RxD_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", RxD_data); end
        total++; if (RxD_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", RxD_data_ready); end
        total++; if (RxD_frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", RxD_frame_error); end
        total++; if (RxD_idle !== 1'b0) begin bad++; $display("FAIL reset_idle: got %b expected 0", RxD_idle); end
        total++; if (RxD_endofpacket !== 1'b0) begin bad++; $display("FAIL reset_eop: got %b expected 0", RxD_endofpacket); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int r0 = ready_cnt;
        int e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        bit_time(1);
        total++; if (ready_cnt - r0 != 1) begin bad++; $display("FAIL basic_ready_count: got %0d expected 1", ready_cnt - r0); end
        total++; if (RxD_data !== 8'h55) begin bad++; $display("FAIL basic_data: got %h expected 55", RxD_data); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL basic_ferr_count: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int r0 = ready_cnt;
        int e0 = err_cnt;
        RxD = 1'b0;
        repeat (29) @(negedge clk);
        RxD = 1'b1;
        bit_time(3);
        total++; if (ready_cnt - r0 != 0) begin bad++; $display("FAIL glitch_ready_count: got %0d expected 0", ready_cnt - r0); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL glitch_ferr_count: got %0d expected 0", err_cnt - e0); end
        total++; if (RxD_data !== 8'h55) begin bad++; $display("FAIL glitch_data: got %h expected 55", RxD_data); end
    endtask

    task automatic test_frame_error;
        int r0 = ready_cnt;
        int e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        bit_time(1);
        RxD = 1'b1;
        bit_time(2);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL ferr_count: got %0d expected 1", err_cnt - e0); end
        total++; if (ready_cnt - r0 != 0) begin bad++; $display("FAIL ferr_ready_count: got %0d expected 0", ready_cnt - r0); end
        total++; if (RxD_data !== 8'h55) begin bad++; $display("FAIL ferr_data_kept: got %h expected 55", RxD_data); end
        send_byte(8'h3C, 1'b1);
        bit_time(1);
        total++; if (ready_cnt - r0 != 1) begin bad++; $display("FAIL after_break_ready_count: got %0d expected 1", ready_cnt - r0); end
        total++; if (RxD_data !== 8'h3C) begin bad++; $display("FAIL after_break_data: got %h expected 3c", RxD_data); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL after_break_ferr_count: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int r0 = ready_cnt;
        int e0 = err_cnt;
        int n0 = log_q.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        bit_time(1);
        total++; if (ready_cnt - r0 != 2) begin bad++; $display("FAIL b2b_ready_count: got %0d expected 2", ready_cnt - r0); end
        total++;
        if (log_q.size() < n0 + 1 || log_q[n0] !== 8'h00) begin
            bad++; $display("FAIL b2b_first: got %0d entries expected 00 at index %0d", log_q.size(), n0);
        end
        total++;
        if (log_q.size() < n0 + 2 || log_q[n0+1] !== 8'hFF) begin
            bad++; $display("FAIL b2b_second: got %0d entries expected ff at index %0d", log_q.size(), n0 + 1);
        end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL b2b_ferr_count: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_reset_mid;
        int r0 = ready_cnt;
        int e0 = err_cnt;
        logic [7:0] b = 8'h81;
        RxD = 1'b0;
        bit_time(1);
        for (int i = 0; i < 3; i++) begin
            RxD = b[i];
            bit_time(1);
        end
        RxD = b[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (RxD_data !== 8'h00) begin bad++; $display("FAIL midrst_data_in_reset: got %h expected 00", RxD_data); end
        rst = 1'b0;
        RxD = 1'b1;
        bit_time(3);
        total++; if (ready_cnt - r0 != 0) begin bad++; $display("FAIL midrst_ready_count: got %0d expected 0", ready_cnt - r0); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL midrst_ferr_count: got %0d expected 0", err_cnt - e0); end
        total++; if (RxD_data !== 8'h00) begin bad++; $display("FAIL midrst_data_after: got %h expected 00", RxD_data); end
        send_byte(8'h7E, 1'b1);
        bit_time(1);
        total++; if (ready_cnt - r0 != 1) begin bad++; $display("FAIL midrst_next_ready_count: got %0d expected 1", ready_cnt - r0); end
        total++; if (RxD_data !== 8'h7E) begin bad++; $display("FAIL midrst_next_data: got %h expected 7e", RxD_data); end
    endtask

    task automatic test_idle;
        int q0 = eop_cnt;
        int wait_clks = 0;
        send_byte(8'h12, 1'b1);
        total++; if (RxD_idle !== 1'b0) begin bad++; $display("FAIL idle_low_after_frame: got %b expected 0", RxD_idle); end
        while (RxD_idle !== 1'b1 && wait_clks < 4000) begin
            @(negedge clk);
            wait_clks++;
        end
        total++;
        if (wait_clks < 2200 || wait_clks > 2520) begin
            bad++; $display("FAIL idle_rise_time: got %0d clks expected 2200..2520", wait_clks);
        end
        total++; if (RxD_data !== 8'h12) begin bad++; $display("FAIL idle_data: got %h expected 12", RxD_data); end
        @(negedge clk);
        total++; if (eop_cnt - q0 != 1) begin bad++; $display("FAIL eop_count: got %0d expected 1", eop_cnt - q0); end
        bit_time(2);
        total++; if (RxD_idle !== 1'b1) begin bad++; $display("FAIL idle_held: got %b expected 1", RxD_idle); end
        total++; if (eop_cnt - q0 != 1) begin bad++; $display("FAIL eop_no_repeat: got %0d expected 1", eop_cnt - q0); end
        RxD = 1'b0;
        bit_time(1);
        total++; if (RxD_idle !== 1'b0) begin bad++; $display("FAIL idle_drop_on_start: got %b expected 0", RxD_idle); end
        RxD = 1'b1;
        bit_time(10);
        total++; if (RxD_data !== 8'hFF) begin bad++; $display("FAIL idle_next_data: got %h expected ff", RxD_data); end
        total++; if (eop_cnt - q0 != 1) begin bad++; $display("FAIL eop_after_start: got %0d expected 1", eop_cnt - q0); end
        total++; if (eop_bad_cnt != 0) begin bad++; $display("FAIL eop_alignment: got %0d misaligned expected 0", eop_bad_cnt); end
        total++; if (both_cnt != 0) begin bad++; $display("FAIL ready_ferr_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_back_to_back;
        test_reset_mid;
        test_idle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
